// File: rtl/majority_accum.sv
// rtl/majority_accum.sv - accumulates NUM_GROUPS 2-bit XNOR popcounts into a neuron sum
// and thresholds it, holding the result under a valid/ready handshake.
module majority_accum #(
  parameter int NUM_GROUPS = 16,
  parameter int ACC_W      = 8,
  parameter int THRESH     = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       m_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [ACC_W-1:0] out_sum
);

  localparam int               CNT_W    = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NUM_GROUPS - 1);
  localparam logic [ACC_W-1:0] THRESH_V = ACC_W'(THRESH);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_out_sum;
  logic [ACC_W-1:0]   w_sum;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_bit;
  logic               w_accept;
  logic               w_last;

  // clr suppresses the accept so an input presented alongside it is dropped
  assign w_accept = in_valid && (r_state == ST_ACCUM) && !clr;
  assign w_last   = (r_cnt == LAST_GRP);
  assign w_sum    = r_acc + {{(ACC_W-2){1'b0}}, m_in};

  assign in_ready  = (r_state == ST_ACCUM);
  assign out_valid = (r_state == ST_DONE);
  assign out_bit   = r_out_bit;
  assign out_sum   = r_out_sum;

  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = ST_ACCUM;
    end else begin
      case (r_state)
        ST_ACCUM: if (w_accept && w_last) w_state_nxt = ST_DONE;
        ST_DONE:  if (out_ready)          w_state_nxt = ST_ACCUM;
        default:                          w_state_nxt = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_out_sum <= '0;
      r_out_bit <= 1'b0;
    end else if (clr) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_out_sum <= '0;
      r_out_bit <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        r_out_sum <= w_sum;
        r_out_bit <= (w_sum >= THRESH_V);
        r_acc     <= '0;
        r_cnt     <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_majority_accum.sv
// tb/tb_majority_accum.sv - directed and random checks of two majority_accum instances
// (4 groups / threshold 7, and default parameters) against a value-list reference model.
module tb_majority_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr  [2];
  logic       iv   [2];
  logic       ordy [2];
  logic       rdy  [2];
  logic       ov   [2];
  logic       ob   [2];
  logic [1:0] m    [2];
  logic [7:0] os   [2];

  int checks   = 0;
  int failures = 0;

  int         ng [2] = '{4, 16};
  int         th [2] = '{7, 25};
  int         vals [2][64];
  int         nv   [2];
  bit         pend [2];
  logic [7:0] esum [2];
  logic       ebit [2];

  majority_accum #(.NUM_GROUPS(4), .ACC_W(8), .THRESH(7)) u_small (
    .clk(clk), .rst_n(rst_n), .clr(clr[0]), .in_valid(iv[0]), .in_ready(rdy[0]),
    .m_in(m[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_bit(ob[0]), .out_sum(os[0])
  );

  majority_accum #(.NUM_GROUPS(16), .ACC_W(8), .THRESH(25)) u_dflt (
    .clk(clk), .rst_n(rst_n), .clr(clr[1]), .in_valid(iv[1]), .in_ready(rdy[1]),
    .m_in(m[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_bit(ob[1]), .out_sum(os[1])
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      nv[k] = 0; pend[k] = 1'b0; esum[k] = 8'd0; ebit[k] = 1'b0;
    end
  endfunction

  // Neuron = list of accepted values; result is their plain integer sum.
  function automatic void model_step();
    for (int k = 0; k < 2; k++) begin
      if (clr[k]) begin
        nv[k] = 0; pend[k] = 1'b0; esum[k] = 8'd0; ebit[k] = 1'b0;
      end else if (pend[k]) begin
        if (ordy[k]) pend[k] = 1'b0;
      end else if (iv[k]) begin
        vals[k][nv[k]] = int'(m[k]);
        nv[k]++;
        if (nv[k] == ng[k]) begin
          int s;
          s = 0;
          for (int i = 0; i < ng[k]; i++) s += vals[k][i];
          esum[k] = 8'(s);
          ebit[k] = (s >= th[k]);
          pend[k] = 1'b1;
          nv[k]   = 0;
        end
      end
    end
  endfunction

  task automatic check_val(input string tag, input int k, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, k, act, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check_val("in_ready",  k, {7'd0, rdy[k]}, {7'd0, ~pend[k]});
      check_val("out_valid", k, {7'd0, ov[k]},  {7'd0, pend[k]});
      check_val("out_sum",   k, os[k],          esum[k]);
      check_val("out_bit",   k, {7'd0, ob[k]},  {7'd0, ebit[k]});
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send(input int k, input int v);
    iv[k] = 1'b1;
    m[k]  = 2'(v);
    tick();
  endtask

  task automatic idle(input int k, input int n);
    iv[k] = 1'b0;
    repeat (n) tick();
  endtask

  task automatic expect_res(input int k, input int s, input int b);
    check_val("res_valid", k, {7'd0, ov[k]}, 8'd1);
    check_val("res_sum",   k, os[k],         8'(s));
    check_val("res_bit",   k, {7'd0, ob[k]}, 8'(b));
  endtask

  int gp [7] = '{1, -1, -1, 1, -1, 1, 1};

  initial begin
    for (int k = 0; k < 2; k++) begin
      clr[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b0; m[k] = 2'd0;
    end
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all();
    #10;
    rst_n = 1'b1;

    // back-to-back neuron, result taken immediately
    ordy[0] = 1'b1;
    send(0, 3); send(0, 3); send(0, 0); send(0, 1);
    expect_res(0, 7, 1);
    idle(0, 1);
    check_val("valid_drop", 0, {7'd0, ov[0]}, 8'd0);

    send(0, 2); send(0, 2); send(0, 1); send(0, 1);
    expect_res(0, 6, 0);
    idle(0, 1);
    send(0, 3); send(0, 3); send(0, 3); send(0, 3);
    expect_res(0, 12, 1);
    idle(0, 1);

    // backpressure: inputs offered while DONE must not be absorbed
    ordy[0] = 1'b0;
    send(0, 3); send(0, 3); send(0, 0); send(0, 1);
    expect_res(0, 7, 1);
    iv[0] = 1'b1; m[0] = 2'd2;
    repeat (5) begin
      tick();
      expect_res(0, 7, 1);
    end
    ordy[0] = 1'b1;
    tick();
    repeat (4) tick();
    expect_res(0, 8, 1);
    idle(0, 1);

    // gapped input
    foreach (gp[i]) begin
      if (gp[i] < 0) idle(0, 1);
      else send(0, gp[i]);
    end
    expect_res(0, 4, 0);
    idle(0, 1);

    // clr with a simultaneous input drops both partial sum and that input
    send(0, 3); send(0, 3);
    clr[0] = 1'b1; iv[0] = 1'b1; m[0] = 2'd3;
    tick();
    clr[0] = 1'b0;
    send(0, 1); send(0, 1); send(0, 1); send(0, 1);
    expect_res(0, 4, 0);
    idle(0, 1);

    // async reset mid-stream, observed before the next clock edge
    send(0, 2); send(0, 2);
    iv[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check_val("rst_ready", 0, {7'd0, rdy[0]}, 8'd1);
    #2;
    rst_n = 1'b1;
    idle(0, 1);

    // default parameters: threshold boundary and full-scale sum
    ordy[1] = 1'b1;
    repeat (8) send(1, 3);
    repeat (8) send(1, 0);
    expect_res(1, 24, 0);
    idle(1, 1);
    repeat (8) send(1, 3);
    send(1, 1);
    repeat (7) send(1, 0);
    expect_res(1, 25, 1);
    idle(1, 1);
    repeat (16) send(1, 3);
    expect_res(1, 48, 1);
    idle(1, 1);

    // random traffic on both instances
    repeat (600) begin
      for (int k = 0; k < 2; k++) begin
        iv[k]   = ($urandom_range(0, 3) != 0);
        m[k]    = 2'($urandom_range(0, 3));
        ordy[k] = ($urandom_range(0, 3) != 0);
        clr[k]  = ($urandom_range(0, 49) == 0);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; clr[k] = 1'b0; ordy[k] = 1'b1;
    end
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
